// File: rtl/lsu_pkg.sv
// Shared types, constants and helpers for the halfword load/store unit.
package lsu_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned HALF  = 16;
    localparam int unsigned BE_W  = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [BE_W-1:0] BE_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HI = 4'b1100;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } mem_cmd_t;

    function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] h);
        return {{(XLEN-HALF){h[HALF-1]}}, h};
    endfunction
endpackage

// File: rtl/lsu_halfword_if.sv
// Core request/response and data-memory port signals of the halfword LSU.
interface lsu_halfword_if;
    import lsu_pkg::*;

    logic            start;
    logic            is_store;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] store_data;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] load_data;
    logic            err_misaligned;
    logic            err_timeout;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [BE_W-1:0] mem_be;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output start, is_store, addr, store_data, mem_ready, mem_rdata,
        input  busy, done, load_data, err_misaligned, err_timeout,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  start, is_store, addr, store_data, mem_ready, mem_rdata,
        output busy, done, load_data, err_misaligned, err_timeout,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/lsu_half_lane.sv
// Byte-lane steering for halfword accesses: enables, write replication,
// read lane select with sign extension, and misalignment detection.
module lsu_half_lane
    import lsu_pkg::*;
(
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic [BE_W-1:0] be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] load_ext_c,
    output logic            misaligned_c
);
    // Only the low halfword of rs2 is ever stored.
    logic unused_store_hi;
    assign unused_store_hi = ^store_data_i[XLEN-1:HALF];

    assign misaligned_c = addr_lo_i[0];
    assign be_c         = addr_lo_i[1] ? BE_HI : BE_LO;
    assign wdata_c      = {store_data_i[HALF-1:0], store_data_i[HALF-1:0]};
    assign load_ext_c   = sext_half(addr_lo_i[1] ? mem_rdata_i[XLEN-1:HALF]
                                                 : mem_rdata_i[HALF-1:0]);
endmodule

// File: rtl/lsu_halfword.sv
// Halfword load/store unit: one data-memory transaction per lh/sh request,
// with misalignment rejection and a bounded wait for mem_ready.
module lsu_halfword
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic           clk,
    input logic           rst_n,
    lsu_halfword_if.slave bus
);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_e       state_q, state_d;
    mem_cmd_t         cmd_q, cmd_d;
    logic             is_store_q, is_store_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  load_data_q, load_data_d;
    logic             mem_req_q, mem_req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_mis_q, err_mis_d;
    logic             err_to_q, err_to_d;

    logic [1:0]       lane_addr_lo;
    logic [BE_W-1:0]  be_c;
    logic [XLEN-1:0]  wdata_c;
    logic [XLEN-1:0]  load_ext_c;
    logic             misaligned_c;

    // Lane unit sees the incoming address while idle and the latched one afterwards.
    assign lane_addr_lo = (state_q == IDLE) ? bus.addr[1:0] : addr_lo_q;

    lsu_half_lane u_lane (
        .addr_lo_i    (lane_addr_lo),
        .store_data_i (bus.store_data),
        .mem_rdata_i  (bus.mem_rdata),
        .be_c         (be_c),
        .wdata_c      (wdata_c),
        .load_ext_c   (load_ext_c),
        .misaligned_c (misaligned_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            is_store_q  <= 1'b0;
            addr_lo_q   <= 2'b00;
            cnt_q       <= '0;
            load_data_q <= '0;
            mem_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_mis_q   <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            is_store_q  <= is_store_d;
            addr_lo_q   <= addr_lo_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            mem_req_q   <= mem_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_mis_q   <= err_mis_d;
            err_to_q    <= err_to_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        is_store_d  = is_store_q;
        addr_lo_d   = addr_lo_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        err_mis_d   = 1'b0;
        err_to_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (misaligned_c) begin
                        state_d   = DONE;
                        err_mis_d = 1'b1;
                    end else begin
                        state_d    = REQ;
                        cmd_d.we   = bus.is_store;
                        cmd_d.addr = {bus.addr[XLEN-1:2], 2'b00};
                        cmd_d.wdata = wdata_c;
                        cmd_d.be   = be_c;
                        is_store_d = bus.is_store;
                        addr_lo_d  = bus.addr[1:0];
                        cnt_d      = '0;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ready) begin
                    state_d = DONE;
                    if (!is_store_q) begin
                        load_data_d = load_ext_c;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == TO_LIMIT) begin
                        state_d  = DONE;
                        err_to_d = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Status outputs are registered copies of the upcoming state.
        mem_req_d = (state_d == REQ);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.load_data      = load_data_q;
    assign bus.err_misaligned = err_mis_q;
    assign bus.err_timeout    = err_to_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_we         = cmd_q.we;
    assign bus.mem_addr       = cmd_q.addr;
    assign bus.mem_wdata      = cmd_q.wdata;
    assign bus.mem_be         = cmd_q.be;
endmodule

// File: tb/tb_lsu_halfword.sv
// Randomized scoreboard bench for lsu_halfword: stimulus pushes expected
// completions and memory commands; monitor and memory responder check them.
module tb_lsu_halfword;
    localparam int unsigned TO    = 15;
    localparam int          NEVER = 1000;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_done;
    logic [31:0] model_ld = 32'h0;

    lsu_halfword_if bus ();

    lsu_halfword #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          n_edge;
        int          done_edge;
        bit          mis;
        bit          tmo;
        logic [31:0] ld;
    } exp_t;

    typedef struct {
        int          n_edge;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        int          waits;
        int          req_cycles;
        logic [31:0] rdata;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    logic        h_st  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] h_addr[4] = '{32'h0000_4000, 32'h0000_4002, 32'h0000_4005, 32'h0000_4006};
    logic [31:0] h_sd  [4] = '{32'h0, 32'h1111_A5A5, 32'h0, 32'h0};
    int          h_w   [4] = '{1, 0, 0, 2};
    logic [31:0] h_rd  [4] = '{32'h1234_ABCD, 32'h0, 32'h0, 32'h7654_0000};

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: pick the addressed halfword and sign-extend it arithmetically.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] h;
        h = a[1] ? (rd / 32'd65536) : (rd % 32'd65536);
        return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
    endfunction

    task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] sd,
                         input int w, input logic [31:0] rd, input int n_edge, output int d_edge);
        exp_t e;
        mem_t m;
        while (cyc < n_edge - 1) @(negedge clk);
        bus.start      = 1'b1;
        bus.is_store   = st;
        bus.addr       = a;
        bus.store_data = sd;
        e.n_edge = n_edge;
        e.mis    = a[0];
        e.tmo    = !a[0] && (w >= int'(TO));
        if (e.mis) d_edge = n_edge;
        else if (e.tmo) d_edge = n_edge + int'(TO);
        else begin
            d_edge = n_edge + 1 + w;
            if (!st) model_ld = ref_load(a, rd);
        end
        e.done_edge = d_edge;
        e.ld        = model_ld;
        exp_q.push_back(e);
        if (!e.mis) begin
            m.n_edge     = n_edge;
            m.addr       = a - (a % 32'd4);
            m.be         = a[1] ? 4'b1100 : 4'b0011;
            m.we         = st;
            m.wdata      = 32'((sd % 32'd65536) * 32'd65537);
            m.waits      = w;
            m.req_cycles = e.tmo ? int'(TO) : w + 1;
            m.rdata      = rd;
            mem_q.push_back(m);
        end
    endtask

    task automatic txn(input logic st, input logic [31:0] a, input logic [31:0] sd,
                       input int w, input logic [31:0] rd, input int gap);
        int d;
        issue(st, a, sd, w, rd, last_done + 2 + gap, d);
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < d) @(negedge clk);
        last_done = d;
    endtask

    // Completion monitor: busy window, done timing, error flags, load_data.
    logic [31:0] mon_ld = 32'h0;
    always @(negedge clk) begin
        exp_t e;
        bit   busy_exp;
        if (!rst_n) begin
            mon_ld = 32'h0;
        end else begin
            busy_exp = (exp_q.size() > 0) && (cyc >= exp_q[0].n_edge) && (cyc <= exp_q[0].done_edge);
            check32("busy", 32'(bus.busy), 32'(busy_exp));
            if (bus.done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done: unexpected done pulse at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check32("done_cycle", 32'(cyc), 32'(e.done_edge));
                    check32("err_misaligned", 32'(bus.err_misaligned), 32'(e.mis));
                    check32("err_timeout", 32'(bus.err_timeout), 32'(e.tmo));
                    mon_ld = e.ld;
                end
            end else begin
                check32("err_idle", {30'h0, bus.err_misaligned, bus.err_timeout}, 32'h0);
            end
            check32("load_data", bus.load_data, mon_ld);
        end
    end

    // Memory responder: checks request fields every cycle, answers after the planned waits.
    int   k;
    bit   active = 1'b0;
    always @(negedge clk) begin
        mem_t m;
        if (!rst_n) begin
            active        = 1'b0;
            bus.mem_ready = 1'b0;
        end else if (bus.mem_req) begin
            if (!active) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_req: unexpected request at cycle %0d", cyc);
                end else begin
                    active = 1'b1;
                    k      = 0;
                    check32("mem_req_rise", 32'(cyc), 32'(mem_q[0].n_edge));
                end
            end
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            if (active) begin
                m = mem_q[0];
                check32("mem_addr", bus.mem_addr, m.addr);
                check32("mem_be", 32'(bus.mem_be), 32'(m.be));
                check32("mem_we", 32'(bus.mem_we), 32'(m.we));
                check32("mem_wdata", bus.mem_wdata, m.wdata);
                if (k == m.waits) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = m.rdata;
                end
                k++;
            end
        end else begin
            if (active) begin
                m      = mem_q.pop_front();
                active = 1'b0;
                check32("mem_req_cycles", 32'(k), 32'(m.req_cycles));
            end
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int          d;
        int          n;
        logic        st;
        logic [31:0] a;
        int          w;
        bus.start      = 1'b0;
        bus.is_store   = 1'b0;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'h0;
        rst_n          = 1'b0;
        #1;
        check32("rst_busy", 32'(bus.busy), 32'h0);
        check32("rst_done", 32'(bus.done), 32'h0);
        check32("rst_load_data", bus.load_data, 32'h0);
        check32("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check32("rst_mem_be", 32'(bus.mem_be), 32'h0);
        check32("rst_mem_addr", bus.mem_addr, 32'h0);
        check32("rst_errs", {30'h0, bus.err_misaligned, bus.err_timeout}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        last_done = cyc - 1;

        txn(1'b0, 32'h0000_1002, 32'h0, 0, 32'h8001_1234, 0);
        check32("lh_sext_hi", bus.load_data, 32'hFFFF_8001);
        txn(1'b1, 32'h0000_1000, 32'hDEAD_7FFF, 3, $urandom, 1);
        txn(1'b0, 32'h0000_2001, 32'h0, 0, 32'h0, 0);
        txn(1'b0, 32'h0000_1004, 32'h0, NEVER, 32'h0, 2);
        check32("timeout_keeps_ld", bus.load_data, 32'hFFFF_8001);

        // Asynchronous reset in the middle of a waiting request.
        n = last_done + 2;
        issue(1'b0, 32'h0000_1000, 32'h0, NEVER, 32'h0, n, d);
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < n + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check32("arst_mem_req", 32'(bus.mem_req), 32'h0);
        check32("arst_busy", 32'(bus.busy), 32'h0);
        check32("arst_load_data", bus.load_data, 32'h0);
        check32("arst_mem_be", 32'(bus.mem_be), 32'h0);
        exp_q.delete();
        mem_q.delete();
        model_ld = 32'h0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        last_done = cyc - 1;
        txn(1'b0, 32'h0000_1000, 32'h0, 0, 32'h0000_0050, 0);
        check32("post_reset_lh", bus.load_data, 32'h0000_0050);

        // A start pulse during the done cycle must be dropped.
        txn(1'b1, 32'h0000_3002, 32'h0000_BEEF, 1, 32'h0, 0);
        bus.start    = 1'b1;
        bus.is_store = 1'b0;
        bus.addr     = 32'h0000_3000;
        @(negedge clk);
        bus.start = 1'b0;

        // start held high: one transaction per IDLE entry.
        for (int i = 0; i < 4; i++) begin
            n = (i == 0) ? last_done + 3 : d + 2;
            issue(h_st[i], h_addr[i], h_sd[i], h_w[i], h_rd[i], n, d);
            while (cyc < d) @(negedge clk);
        end
        bus.start = 1'b0;
        last_done = d;

        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            a  = $urandom;
            a  = a - (a % 32'd2);
            n  = $urandom_range(0, 9);
            if (n < 2) a = a + 32'd1;
            if (n == 2) a = 32'hFFFF_FFFE;
            w = $urandom_range(0, 4);
            if ($urandom_range(0, 11) == 0) w = NEVER;
            txn(st, a, $urandom, w, $urandom, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check32("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check32("mem_q_drained", 32'(mem_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_halfword.md
Name: lsu_halfword

Overview:
- Load/store unit that consumes the ALU address result (rs1 + offset) for lh and sh and runs one data-memory transaction per request.
- Sits between the execute stage, which supplies the ALU result and rs2, and the data-memory port.
- Performs byte-lane steering, sign extension and misalignment detection, and bounds each memory wait with a timeout.

Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles mem_req stays high without mem_ready before the transaction aborts; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request pulse from the core; sampled only in IDLE
- is_store  in  1  1 = sh, 0 = lh; sampled with start
- addr  in  32  byte address from the ALU result; sampled with start
- store_data  in  32  rs2 value; bits [15:0] are stored; sampled with start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- load_data  out  32  sign-extended halfword; updated only on a successful load
- err_misaligned  out  1  qualifies done: addr[0] was 1
- err_timeout  out  1  qualifies done: mem_ready did not arrive
- mem_req  out  1  memory request; held until accepted
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address {addr[31:2], 2'b00}
- mem_wdata  out  32  {store_data[15:0], store_data[15:0]}
- mem_be  out  4  byte enables
- mem_ready  in  1  memory accept/response strobe
- mem_rdata  in  32  read data; valid in the same cycle as mem_ready

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. All outputs go to 0, including load_data and mem_be. The timeout counter goes to 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - start=1 with addr[0]=0: latch the request and go to REQ.
  - start=1 with addr[0]=1: go to DONE with err_misaligned=1. No memory request is issued.
  - start=0: stay in IDLE.
- start while busy is ignored. There is no queueing.
- REQ:
  - mem_req=1. mem_we, mem_addr, mem_wdata and mem_be are registered and stay stable while mem_req is high.
  - mem_be is 4'b0011 when addr[1]=0 and 4'b1100 when addr[1]=1.
  - For a load, mem_we=0 and mem_be still shows the selected lanes.
  - mem_ready=1 is sampled at the rising edge: go to DONE and drop mem_req in the next cycle.
  - For a load, load_data is captured from mem_rdata at the same edge: mem_rdata[15:0] when addr[1]=0, mem_rdata[31:16] when addr[1]=1, sign-extended from bit 15.
  - The counter increments on each REQ cycle without mem_ready. When the counter reaches TIMEOUT_CYCLES, go to DONE with err_timeout=1 and drop mem_req.
  - A timeout abort never modifies load_data.
- DONE:
  - done=1 for exactly one cycle, then go to IDLE.
  - The error flags are valid only while done=1 and are 0 otherwise.
  - A successful transaction has both error flags at 0.
- Latency:
  - start at edge N gives mem_req high in cycle N+1.
  - With zero-wait memory (mem_ready=1 in the first REQ cycle), done is high in cycle N+2.
  - Each wait cycle adds one.
  - Misaligned requests: done in cycle N+1.
- mem_ready while not in REQ is ignored.
- Back-to-back: start may be asserted in the cycle done is high, but it is dropped, because that cycle is not IDLE. The earliest accepted restart is the cycle after done.
- Address arithmetic is unsigned. Wrap-around at 0xFFFF_FFFE is legal and needs no special case.

Decomposition:
- Package lsu_pkg holds:
  - state encoding: IDLE=2'd0, REQ=2'd1, DONE=2'd2
  - BE_LO=4'b0011 and BE_HI=4'b1100
  - the halfword sign-extension function
- Sub-module lsu_half_lane is combinational. It takes the latched addr[1:0], store_data and mem_rdata, and produces mem_be, mem_wdata, the extended load value and the misaligned flag.
- The FSM and timeout counter stay in lsu_halfword.

Test Plan:
- lh, addr=0x0000_1002, mem_rdata=0x8001_1234, mem_ready on the first REQ cycle -> mem_addr=0x0000_1000, mem_be=1100, mem_we=0; done at start+2 with load_data=0xFFFF_8001 and no errors.
- sh, addr=0x0000_1000, store_data=0xDEAD_7FFF, 3 wait cycles -> mem_req and all mem_* signals stable for 4 cycles; mem_we=1, mem_be=0011, mem_wdata=0x7FFF_7FFF; done at start+5; load_data unchanged.
- lh, addr=0x0000_2001 -> mem_req never rises; done at start+1 with err_misaligned=1.
- lh with mem_ready held at 0, TIMEOUT_CYCLES=15 -> mem_req high for exactly 15 cycles, then done with err_timeout=1; load_data keeps its previous value 0xFFFF_8001.
- rst_n low during REQ after 2 wait cycles -> mem_req, busy and load_data go to 0 immediately without a clock edge; after release, a fresh lh to 0x0000_1000 with rdata 0x0000_0050 gives load_data=0x0000_0050.
- start held high through an entire transaction -> exactly one transaction per IDLE entry, restarting the cycle after each done pulse.
